// File: rtl/axis_distributor_pkg.sv
// Shared definitions for the AXI-Stream distributor: FSM state encoding and selector field positions.
package axis_distributor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PASS   = 2'd1,
        ST_SWITCH = 2'd2
    } dist_state_t;

    localparam int NUM_OUTPUTS    = 8;
    localparam int SEL_DEST_LSB   = 0;
    localparam int SEL_DEST_MSB   = 2;
    localparam int SEL_BCAST_BIT  = 3;
    localparam int SEL_ENABLE_BIT = 4;
    localparam int SEL_SINK_BIT   = 5;

endpackage

// File: rtl/axis_distributor_out.sv
// One output stage: a single-beat data/valid register that can be reloaded while it drains.
module axis_out_reg #(
    parameter int TDATA_WIDTH = 32
) (
    input  logic                   a_clk,
    input  logic                   a_rst,
    input  logic                   load,
    input  logic [TDATA_WIDTH-1:0] load_data,
    output logic [TDATA_WIDTH-1:0] tdata,
    output logic                   tvalid,
    input  logic                   tready,
    output logic                   free
);

    // Load has priority over draining so a back-to-back beat keeps valid high.
    always_ff @(posedge a_clk) begin
        if (a_rst) begin
            tvalid <= 1'b0;
            tdata  <= '0;
        end else if (load) begin
            tvalid <= 1'b1;
            tdata  <= load_data;
        end else if (tvalid && tready) begin
            tvalid <= 1'b0;
        end
    end

    assign free = ~tvalid | tready;

endmodule

// File: rtl/axis_distributor.sv
// Routes one AXI-Stream source to one of eight outputs, to all of them, or into a sink.
module axis_distributor
    import axis_distributor_pkg::*;
#(
    parameter int TDATA_WIDTH = 32
) (
    input  logic                   a_clk,
    input  logic                   a_rst,
    input  logic [TDATA_WIDTH-1:0] S_AXIS_tdata,
    input  logic                   S_AXIS_tvalid,
    output logic                   S_AXIS_tready,
    input  logic [31:0]            axis_selector,
    output logic [TDATA_WIDTH-1:0] M_AXIS_0_tdata,
    output logic                   M_AXIS_0_tvalid,
    input  logic                   M_AXIS_0_tready,
    output logic [TDATA_WIDTH-1:0] M_AXIS_1_tdata,
    output logic                   M_AXIS_1_tvalid,
    input  logic                   M_AXIS_1_tready,
    output logic [TDATA_WIDTH-1:0] M_AXIS_2_tdata,
    output logic                   M_AXIS_2_tvalid,
    input  logic                   M_AXIS_2_tready,
    output logic [TDATA_WIDTH-1:0] M_AXIS_3_tdata,
    output logic                   M_AXIS_3_tvalid,
    input  logic                   M_AXIS_3_tready,
    output logic [TDATA_WIDTH-1:0] M_AXIS_4_tdata,
    output logic                   M_AXIS_4_tvalid,
    input  logic                   M_AXIS_4_tready,
    output logic [TDATA_WIDTH-1:0] M_AXIS_5_tdata,
    output logic                   M_AXIS_5_tvalid,
    input  logic                   M_AXIS_5_tready,
    output logic [TDATA_WIDTH-1:0] M_AXIS_6_tdata,
    output logic                   M_AXIS_6_tvalid,
    input  logic                   M_AXIS_6_tready,
    output logic [TDATA_WIDTH-1:0] M_AXIS_7_tdata,
    output logic                   M_AXIS_7_tvalid,
    input  logic                   M_AXIS_7_tready,
    output logic [3:0]             sel_active,
    output logic [31:0]            beat_count,
    output logic [31:0]            drop_count
);

    dist_state_t state;
    dist_state_t state_next;

    logic [TDATA_WIDTH-1:0] out_data [NUM_OUTPUTS];
    logic [NUM_OUTPUTS-1:0] out_valid;
    logic [NUM_OUTPUTS-1:0] out_ready;
    logic [NUM_OUTPUTS-1:0] out_free;
    logic [NUM_OUTPUTS-1:0] load_vec;

    logic       sel_enable;
    logic       sel_sink;
    logic [3:0] sel_route;
    logic [2:0] dest_active;
    logic       bcast_active;
    logic       all_empty;
    logic       pass_ready;
    logic       adopt;
    logic       handshake;
    logic       beat_inc;
    logic       drop_inc;
    logic       unused_sel;

    assign sel_enable   = axis_selector[SEL_ENABLE_BIT];
    assign sel_sink     = axis_selector[SEL_SINK_BIT];
    assign sel_route    = axis_selector[SEL_BCAST_BIT:SEL_DEST_LSB];
    assign unused_sel   = ^axis_selector[31:6];
    assign dest_active  = sel_active[SEL_DEST_MSB:SEL_DEST_LSB];
    assign bcast_active = sel_active[SEL_BCAST_BIT];
    assign all_empty    = ~|out_valid;

    assign out_ready = {M_AXIS_7_tready, M_AXIS_6_tready, M_AXIS_5_tready, M_AXIS_4_tready,
                        M_AXIS_3_tready, M_AXIS_2_tready, M_AXIS_1_tready, M_AXIS_0_tready};

    assign handshake = S_AXIS_tvalid & S_AXIS_tready;
    assign beat_inc  = handshake & ~sel_sink;
    assign drop_inc  = handshake & sel_sink;

    // State register.
    always_ff @(posedge a_clk) begin
        if (a_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: a route change must first let every loaded beat leave so order is kept.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (sel_enable) state_next = ST_PASS;
            end
            ST_PASS: begin
                if (!sel_enable)                  state_next = ST_IDLE;
                else if (sel_route != sel_active) state_next = ST_SWITCH;
            end
            ST_SWITCH: begin
                if (all_empty) state_next = sel_enable ? ST_PASS : ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Readiness in PASS: sink always accepts, otherwise the target register(s) must be free.
    always_comb begin
        pass_ready = 1'b0;
        if (sel_sink)          pass_ready = 1'b1;
        else if (bcast_active) pass_ready = &out_free;
        else                   pass_ready = out_free[dest_active];
    end

    // FSM outputs: source ready only while passing, selection adopted on entry to PASS.
    always_comb begin
        S_AXIS_tready = 1'b0;
        adopt         = 1'b0;
        case (state)
            ST_IDLE:   adopt = sel_enable;
            ST_PASS:   S_AXIS_tready = pass_ready;
            ST_SWITCH: adopt = sel_enable & all_empty;
            default:   ;
        endcase
        if (a_rst) begin
            S_AXIS_tready = 1'b0;
            adopt         = 1'b0;
        end
    end

    // Selection register and wrapping beat/drop counters.
    always_ff @(posedge a_clk) begin
        if (a_rst) begin
            sel_active <= '0;
            beat_count <= '0;
            drop_count <= '0;
        end else begin
            if (adopt) sel_active <= sel_route;
            beat_count <= beat_count + {31'd0, beat_inc};
            drop_count <= drop_count + {31'd0, drop_inc};
        end
    end

    // Which output registers take the accepted beat.
    always_comb begin
        load_vec = '0;
        for (int k = 0; k < NUM_OUTPUTS; k++) begin
            load_vec[k] = beat_inc & (bcast_active | (dest_active == 3'(k)));
        end
    end

    for (genvar k = 0; k < NUM_OUTPUTS; k++) begin : g_out
        axis_out_reg #(
            .TDATA_WIDTH(TDATA_WIDTH)
        ) u_out_reg (
            .a_clk     (a_clk),
            .a_rst     (a_rst),
            .load      (load_vec[k]),
            .load_data (S_AXIS_tdata),
            .tdata     (out_data[k]),
            .tvalid    (out_valid[k]),
            .tready    (out_ready[k]),
            .free      (out_free[k])
        );
    end

    assign M_AXIS_0_tdata  = out_data[0];
    assign M_AXIS_1_tdata  = out_data[1];
    assign M_AXIS_2_tdata  = out_data[2];
    assign M_AXIS_3_tdata  = out_data[3];
    assign M_AXIS_4_tdata  = out_data[4];
    assign M_AXIS_5_tdata  = out_data[5];
    assign M_AXIS_6_tdata  = out_data[6];
    assign M_AXIS_7_tdata  = out_data[7];
    assign M_AXIS_0_tvalid = out_valid[0];
    assign M_AXIS_1_tvalid = out_valid[1];
    assign M_AXIS_2_tvalid = out_valid[2];
    assign M_AXIS_3_tvalid = out_valid[3];
    assign M_AXIS_4_tvalid = out_valid[4];
    assign M_AXIS_5_tvalid = out_valid[5];
    assign M_AXIS_6_tvalid = out_valid[6];
    assign M_AXIS_7_tvalid = out_valid[7];

endmodule

// File: tb/tb_axis_distributor.sv
// Directed bench for axis_distributor with a cycle-level reference model and literal spot checks.
module tb_axis_distributor;

    localparam int W = 32;

    logic          a_clk = 1'b0;
    logic          a_rst;
    logic [W-1:0]  s_tdata;
    logic          s_tvalid;
    wire           s_tready;
    logic [31:0]   selector;
    logic [7:0]    m_ready;
    wire  [W-1:0]  m_tdata [8];
    wire  [7:0]    m_tvalid;
    wire  [3:0]    sel_active;
    wire  [31:0]   beat_count;
    wire  [31:0]   drop_count;

    int tests_run;
    int tests_failed;
    logic check_en;
    logic preset_req;

    // Reference model: what each output register must hold, plus routing mode and counters.
    logic          m_on;
    logic          m_drain;
    logic [3:0]    m_sel;
    logic [7:0]    m_v;
    logic [W-1:0]  m_d [8];
    logic [31:0]   m_beats;
    logic [31:0]   m_drops;

    always #5 a_clk = ~a_clk;

    axis_distributor #(.TDATA_WIDTH(W)) dut (
        .a_clk(a_clk), .a_rst(a_rst),
        .S_AXIS_tdata(s_tdata), .S_AXIS_tvalid(s_tvalid), .S_AXIS_tready(s_tready),
        .axis_selector(selector),
        .M_AXIS_0_tdata(m_tdata[0]), .M_AXIS_0_tvalid(m_tvalid[0]), .M_AXIS_0_tready(m_ready[0]),
        .M_AXIS_1_tdata(m_tdata[1]), .M_AXIS_1_tvalid(m_tvalid[1]), .M_AXIS_1_tready(m_ready[1]),
        .M_AXIS_2_tdata(m_tdata[2]), .M_AXIS_2_tvalid(m_tvalid[2]), .M_AXIS_2_tready(m_ready[2]),
        .M_AXIS_3_tdata(m_tdata[3]), .M_AXIS_3_tvalid(m_tvalid[3]), .M_AXIS_3_tready(m_ready[3]),
        .M_AXIS_4_tdata(m_tdata[4]), .M_AXIS_4_tvalid(m_tvalid[4]), .M_AXIS_4_tready(m_ready[4]),
        .M_AXIS_5_tdata(m_tdata[5]), .M_AXIS_5_tvalid(m_tvalid[5]), .M_AXIS_5_tready(m_ready[5]),
        .M_AXIS_6_tdata(m_tdata[6]), .M_AXIS_6_tvalid(m_tvalid[6]), .M_AXIS_6_tready(m_ready[6]),
        .M_AXIS_7_tdata(m_tdata[7]), .M_AXIS_7_tvalid(m_tvalid[7]), .M_AXIS_7_tready(m_ready[7]),
        .sel_active(sel_active), .beat_count(beat_count), .drop_count(drop_count)
    );

    // Source may transfer only while routing is settled and the target(s) can take a beat.
    function automatic logic exp_ready();
        logic [7:0] free_mask;
        if (a_rst || !m_on || m_drain) return 1'b0;
        if (selector[5]) return 1'b1;
        free_mask = ~m_v | m_ready;
        if (m_sel[3]) return &free_mask;
        return free_mask[m_sel[2:0]];
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic [31:0] sel, input logic valid,
                                 input logic [W-1:0] data, input logic [7:0] rdy);
        a_rst    = rst;
        selector = sel;
        s_tvalid = valid;
        s_tdata  = data;
        m_ready  = rdy;
    endtask

    task automatic tick();
        @(posedge a_clk);
        #1;
    endtask

    // Advance the model by one clock edge.
    always @(posedge a_clk) begin : model
        logic hs;
        logic was_empty;
        if (a_rst) begin
            m_on = 1'b0; m_drain = 1'b0; m_sel = '0; m_v = '0;
            for (int k = 0; k < 8; k++) m_d[k] = '0;
            m_beats = '0; m_drops = '0;
        end else begin
            hs        = s_tvalid && exp_ready();
            was_empty = (m_v == 8'h00);
            m_v       = m_v & ~m_ready;
            if (preset_req) m_drops = 32'hFFFF_FFFE;
            if (hs && selector[5]) begin
                m_drops = m_drops + 32'd1;
            end else if (hs) begin
                m_beats = m_beats + 32'd1;
                for (int k = 0; k < 8; k++) begin
                    if (m_sel[3] || (m_sel[2:0] == k[2:0])) begin
                        m_v[k] = 1'b1;
                        m_d[k] = s_tdata;
                    end
                end
            end
            if (!m_on) begin
                if (selector[4]) begin m_on = 1'b1; m_sel = selector[3:0]; end
            end else if (!m_drain) begin
                if (!selector[4])               m_on = 1'b0;
                else if (selector[3:0] != m_sel) m_drain = 1'b1;
            end else if (was_empty) begin
                m_drain = 1'b0;
                if (selector[4]) m_sel = selector[3:0];
                else             m_on = 1'b0;
            end
        end
    end

    // Every cycle: all DUT outputs against the model.
    always @(negedge a_clk) begin
        if (check_en) begin
            checkOutput("s_tready", 64'(s_tready), 64'(exp_ready()));
            for (int k = 0; k < 8; k++) begin
                checkOutput($sformatf("m%0d_tvalid", k), 64'(m_tvalid[k]), 64'(m_v[k]));
                checkOutput($sformatf("m%0d_tdata", k), 64'(m_tdata[k]), 64'(m_d[k]));
            end
            checkOutput("sel_active", 64'(sel_active), 64'(m_sel));
            checkOutput("beat_count", 64'(beat_count), 64'(m_beats));
            checkOutput("drop_count", 64'(drop_count), 64'(m_drops));
        end
    end

    initial begin
        tests_run = 0; tests_failed = 0; check_en = 1'b0; preset_req = 1'b0;
        applyStimulus(1'b1, 32'h0, 1'b0, '0, 8'hFF);
        tick();
        check_en = 1'b1;
        tick();
        checkOutput("rst_tready", 64'(s_tready), 64'd0);
        checkOutput("rst_valids", 64'(m_tvalid), 64'h00);
        checkOutput("rst_sel", 64'(sel_active), 64'h0);
        checkOutput("rst_beats", 64'(beat_count), 64'd0);
        checkOutput("rst_drops", 64'(drop_count), 64'd0);

        // Single route to output 3, four back-to-back beats.
        applyStimulus(1'b0, 32'h13, 1'b0, '0, 8'hFF);
        tick();
        checkOutput("t1_sel", 64'(sel_active), 64'h3);
        checkOutput("t1_ready", 64'(s_tready), 64'd1);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 32'h13, 1'b1, W'(32'hA0 + i), 8'hFF);
            tick();
            checkOutput("t1_data", 64'(m_tdata[3]), 64'(32'hA0 + i));
            checkOutput("t1_valids", 64'(m_tvalid), 64'h08);
        end
        applyStimulus(1'b0, 32'h13, 1'b0, '0, 8'hFF);
        tick();
        checkOutput("t1_beats", 64'(beat_count), 64'd4);
        checkOutput("t1_idle_valids", 64'(m_tvalid), 64'h00);

        // Backpressure on output 5.
        applyStimulus(1'b0, 32'h15, 1'b0, '0, 8'hDF);
        tick(); tick();
        checkOutput("t2_sel", 64'(sel_active), 64'h5);
        applyStimulus(1'b0, 32'h15, 1'b1, W'(32'h55), 8'hDF);
        tick();
        applyStimulus(1'b0, 32'h15, 1'b1, W'(32'h56), 8'hDF);
        for (int i = 0; i < 5; i++) begin
            checkOutput("t2_hold", 64'(m_tdata[5]), 64'h55);
            checkOutput("t2_stall", 64'(s_tready), 64'd0);
            checkOutput("t2_beats", 64'(beat_count), 64'd5);
            if (i < 4) tick();
        end
        applyStimulus(1'b0, 32'h15, 1'b1, W'(32'h56), 8'hFF);
        #1;
        checkOutput("t2_release", 64'(s_tready), 64'd1);
        tick();
        checkOutput("t2_next", 64'(m_tdata[5]), 64'h56);
        checkOutput("t2_beats_after", 64'(beat_count), 64'd6);
        applyStimulus(1'b0, 32'h15, 1'b0, '0, 8'hFF);
        tick();

        // Selection change while output 2 is stalled.
        applyStimulus(1'b0, 32'h12, 1'b0, '0, 8'hFB);
        tick(); tick();
        applyStimulus(1'b0, 32'h12, 1'b1, W'(32'h77), 8'hFB);
        tick();
        applyStimulus(1'b0, 32'h16, 1'b1, W'(32'h78), 8'hFB);
        tick(); tick();
        checkOutput("t3_switch_ready", 64'(s_tready), 64'd0);
        checkOutput("t3_hold", 64'(m_tdata[2]), 64'h77);
        applyStimulus(1'b0, 32'h16, 1'b1, W'(32'h78), 8'hFF);
        tick(); tick();
        checkOutput("t3_sel", 64'(sel_active), 64'h6);
        tick();
        checkOutput("t3_valids", 64'(m_tvalid), 64'h40);
        checkOutput("t3_data", 64'(m_tdata[6]), 64'h78);
        applyStimulus(1'b0, 32'h16, 1'b0, '0, 8'hFF);
        tick();

        // Broadcast with output 4 stalled.
        applyStimulus(1'b0, 32'h18, 1'b0, '0, 8'hEF);
        tick(); tick();
        applyStimulus(1'b0, 32'h18, 1'b1, W'(32'hBB), 8'hEF);
        tick();
        checkOutput("t4_all_valid", 64'(m_tvalid), 64'hFF);
        checkOutput("t4_data7", 64'(m_tdata[7]), 64'hBB);
        checkOutput("t4_beats", 64'(beat_count), 64'd9);
        applyStimulus(1'b0, 32'h18, 1'b1, W'(32'hBC), 8'hEF);
        tick(); tick();
        checkOutput("t4_held", 64'(m_tvalid), 64'h10);
        checkOutput("t4_stall", 64'(s_tready), 64'd0);
        checkOutput("t4_beats_once", 64'(beat_count), 64'd9);
        applyStimulus(1'b0, 32'h18, 1'b1, W'(32'hBC), 8'hFF);
        tick();
        checkOutput("t4_second", 64'(m_tdata[0]), 64'hBC);
        applyStimulus(1'b0, 32'h18, 1'b0, '0, 8'hFF);
        tick();

        // Sink mode and drop counter wrap.
        applyStimulus(1'b0, 32'h30, 1'b0, '0, 8'hFF);
        tick(); tick();
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 32'h30, 1'b1, W'(32'hE0 + i), 8'hFF);
            #1;
            checkOutput("t5_ready", 64'(s_tready), 64'd1);
            tick();
            checkOutput("t5_no_valid", 64'(m_tvalid), 64'h00);
        end
        checkOutput("t5_drops", 64'(drop_count), 64'd10);
        applyStimulus(1'b0, 32'h30, 1'b0, '0, 8'hFF);
        tick();
        check_en = 1'b0;
        preset_req = 1'b1;
        force dut.drop_count = 32'hFFFF_FFFE;
        tick();
        preset_req = 1'b0;
        release dut.drop_count;
        check_en = 1'b1;
        applyStimulus(1'b0, 32'h30, 1'b1, W'(32'hF0), 8'hFF);
        tick(); tick(); tick();
        checkOutput("t5_wrap", 64'(drop_count), 64'd1);
        checkOutput("t5_beats_kept", 64'(beat_count), 64'd10);

        // Reset with three outputs holding beats.
        applyStimulus(1'b0, 32'h18, 1'b0, '0, 8'hD5);
        tick(); tick();
        applyStimulus(1'b0, 32'h18, 1'b1, W'(32'hCC), 8'hD5);
        tick();
        applyStimulus(1'b0, 32'h18, 1'b0, '0, 8'hD5);
        tick();
        checkOutput("t6_three", 64'(m_tvalid), 64'h2A);
        applyStimulus(1'b1, 32'h18, 1'b0, '0, 8'hD5);
        tick();
        checkOutput("t6_valids", 64'(m_tvalid), 64'h00);
        checkOutput("t6_beats", 64'(beat_count), 64'd0);
        checkOutput("t6_drops", 64'(drop_count), 64'd0);
        checkOutput("t6_data", 64'(m_tdata[1]), 64'h0);
        applyStimulus(1'b0, 32'h11, 1'b1, W'(32'hD0), 8'hFF);
        tick();
        checkOutput("t6_no_early_hs", 64'(beat_count), 64'd0);
        tick();
        checkOutput("t6_first_hs", 64'(beat_count), 64'd1);
        checkOutput("t6_valid1", 64'(m_tvalid), 64'h02);
        checkOutput("t6_data1", 64'(m_tdata[1]), 64'hD0);
        applyStimulus(1'b0, 32'h11, 1'b0, '0, 8'hFF);
        tick(); tick();

        check_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
